// File: rtl/branch_sequencer_if.sv
// Fetch/branch sequencer bus: instruction fetch response in, PC/strobes/status out.
interface branch_sequencer_if #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   stall;
  logic                   instr_valid;
  logic [7:0]             instr;
  logic [7:0]             operand;
  logic [ADDR_WIDTH-1:0]  target;
  logic                   fetch_req;
  logic [ADDR_WIDTH-1:0]  pc;
  logic                   instr_done;
  logic                   branch_taken;
  logic                   flush;
  logic [COUNT_WIDTH-1:0] taken_count;

  modport master (
    input  stall, instr_valid, instr, operand, target,
    output fetch_req, pc, instr_done, branch_taken, flush, taken_count
  );

  modport slave (
    output stall, instr_valid, instr, operand, target,
    input  fetch_req, pc, instr_done, branch_taken, flush, taken_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// Program counter owner: issues fetches, retires instructions and resolves
// conditional jumps by testing a signed operand against zero.
module branch_sequencer #(
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned          COUNT_WIDTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  branch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_WAIT     = 2'd1,
    S_EVAL     = 2'd2,
    S_REDIRECT = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [2:0]             op_q, op_d;
  logic [7:0]             opnd_q, opnd_d;
  logic [ADDR_WIDTH-1:0]  tgt_q, tgt_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic fetch_req_c, instr_done_c, branch_taken_c, flush_c;
  logic taken_c, zero_c, neg_c;

  // Condition test on the latched signed operand.
  always_comb begin
    zero_c = (opnd_q == 8'd0);
    neg_c  = opnd_q[7];
    unique case (op_q)
      3'b000:  taken_c = 1'b0;
      3'b001:  taken_c = zero_c;
      3'b010:  taken_c = neg_c;
      3'b011:  taken_c = neg_c | zero_c;
      3'b100:  taken_c = 1'b1;
      3'b101:  taken_c = !zero_c;
      3'b110:  taken_c = !neg_c && !zero_c;
      default: taken_c = !neg_c;
    endcase
  end

  // Next state and pulse outputs; stall and reset suppress everything.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    op_d           = op_q;
    opnd_d         = opnd_q;
    tgt_d          = tgt_q;
    cnt_d          = cnt_q;
    fetch_req_c    = 1'b0;
    instr_done_c   = 1'b0;
    branch_taken_c = 1'b0;
    flush_c        = 1'b0;
    if (!bus.stall && !reset) begin
      case (state_q)
        S_FETCH: begin
          fetch_req_c = 1'b1;
          state_d     = S_WAIT;
        end
        S_WAIT: begin
          if (bus.instr_valid) begin
            if (bus.instr[7:6] == 2'b11) begin
              op_d    = bus.instr[2:0];
              opnd_d  = bus.operand;
              tgt_d   = bus.target;
              state_d = S_EVAL;
            end else begin
              pc_d         = pc_q + ADDR_WIDTH'(1);
              instr_done_c = 1'b1;
              state_d      = S_FETCH;
            end
          end
        end
        S_EVAL: begin
          instr_done_c = 1'b1;
          if (taken_c) begin
            pc_d           = tgt_q;
            branch_taken_c = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + COUNT_WIDTH'(1);
            state_d        = S_REDIRECT;
          end else begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
        S_REDIRECT: begin
          flush_c = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      op_q    <= 3'd0;
      opnd_q  <= 8'd0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fetch_req    = fetch_req_c;
  assign bus.instr_done   = instr_done_c;
  assign bus.branch_taken = branch_taken_c;
  assign bus.flush        = flush_c;
  assign bus.pc           = pc_q;
  assign bus.taken_count  = cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed and random instructions checked against
// an instruction-level model; a second 2-bit-counter instance checks saturation.
module tb_branch_sequencer;

  logic clk;
  logic rst;

  branch_sequencer_if #(.ADDR_WIDTH(8), .COUNT_WIDTH(16)) bus0 ();
  branch_sequencer_if #(.ADDR_WIDTH(8), .COUNT_WIDTH(2))  bus1 ();

  assign bus1.stall       = bus0.stall;
  assign bus1.instr_valid = bus0.instr_valid;
  assign bus1.instr       = bus0.instr;
  assign bus1.operand     = bus0.operand;
  assign bus1.target      = bus0.target;

  branch_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .COUNT_WIDTH(16)) dut0 (
    .clock (clk),
    .reset (rst),
    .bus   (bus0.master)
  );

  branch_sequencer #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .COUNT_WIDTH(2)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] m_pc;
  int         m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Jump condition straight from the operation table, on a signed integer.
  function automatic bit model_taken(input logic [2:0] op, input logic [7:0] v8);
    int v;
    v = int'($signed(v8));
    case (op)
      3'd0:    return 1'b0;
      3'd1:    return v == 0;
      3'd2:    return v < 0;
      3'd3:    return v <= 0;
      3'd4:    return 1'b1;
      3'd5:    return v != 0;
      3'd6:    return v > 0;
      default: return v >= 0;
    endcase
  endfunction

  // One instruction: entered at posedge+1 with the DUT in FETCH, leaves it there.
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] opd,
                           input logic [7:0] tgt, input int ws, input int st);
    bit br, tk;
    br = (ins[7:6] == 2'b11);
    tk = br && model_taken(ins[2:0], opd);
    repeat (st) begin
      bus0.stall = 1'b1;
      @(negedge clk);
      chk("fetch_stall_req", 32'(bus0.fetch_req), 32'd0);
      chk("fetch_stall_pc", 32'(bus0.pc), 32'(m_pc));
      @(posedge clk); #1;
    end
    bus0.stall = 1'b0;
    @(negedge clk);
    chk("fetch_req", 32'(bus0.fetch_req), 32'd1);
    chk("fetch_pc", 32'(bus0.pc), 32'(m_pc));
    chk("fetch_done", 32'(bus0.instr_done), 32'd0);
    @(posedge clk); #1;
    repeat (ws) begin
      @(negedge clk);
      chk("wait_req", 32'(bus0.fetch_req), 32'd0);
      chk("wait_done", 32'(bus0.instr_done), 32'd0);
      @(posedge clk); #1;
    end
    bus0.instr_valid = 1'b1;
    bus0.instr       = ins;
    bus0.operand     = opd;
    bus0.target      = tgt;
    repeat (st) begin
      bus0.stall = 1'b1;
      @(negedge clk);
      chk("wait_stall_done", 32'(bus0.instr_done), 32'd0);
      chk("wait_stall_pc", 32'(bus0.pc), 32'(m_pc));
      @(posedge clk); #1;
    end
    bus0.stall = 1'b0;
    @(negedge clk);
    chk("accept_done", 32'(bus0.instr_done), 32'(!br));
    chk("accept_req", 32'(bus0.fetch_req), 32'd0);
    chk("accept_taken", 32'(bus0.branch_taken), 32'd0);
    @(posedge clk); #1;
    // Scramble the bus so the DUT must rely on its own latched copy.
    bus0.instr_valid = 1'b0;
    bus0.operand     = ~opd;
    bus0.target      = ~tgt;
    bus0.instr       = 8'($urandom);
    if (br) begin
      @(negedge clk);
      chk("eval_done", 32'(bus0.instr_done), 32'd1);
      chk("eval_taken", 32'(bus0.branch_taken), 32'(tk));
      chk("eval_flush", 32'(bus0.flush), 32'd0);
      @(posedge clk); #1;
      if (tk) begin
        @(negedge clk);
        chk("redirect_flush", 32'(bus0.flush), 32'd1);
        chk("redirect_done", 32'(bus0.instr_done), 32'd0);
        chk("redirect_req", 32'(bus0.fetch_req), 32'd0);
        @(posedge clk); #1;
      end
    end
    m_pc = tk ? tgt : 8'(m_pc + 8'd1);
    if (tk) m_cnt++;
    chk("pc_after", 32'(bus0.pc), 32'(m_pc));
    chk("pc_after_w2", 32'(bus1.pc), 32'(m_pc));
    chk("count16", 32'(bus0.taken_count), 32'(m_cnt));
    chk("count2_sat", 32'(bus1.taken_count), 32'((m_cnt > 3) ? 3 : m_cnt));
  endtask

  initial begin
    logic [7:0] opnds [5];
    opnds[0] = 8'h80; opnds[1] = 8'hFF; opnds[2] = 8'h00; opnds[3] = 8'h01; opnds[4] = 8'h7F;
    rst = 1'b1;
    bus0.stall = 1'b0; bus0.instr_valid = 1'b0;
    bus0.instr = 8'h00; bus0.operand = 8'h00; bus0.target = 8'h00;
    m_pc = 8'h00; m_cnt = 0;

    @(negedge clk);
    chk("reset_pc", 32'(bus0.pc), 32'h0);
    chk("reset_count", 32'(bus0.taken_count), 32'h0);
    chk("reset_req", 32'(bus0.fetch_req), 32'd0);
    chk("reset_done", 32'(bus0.instr_done), 32'd0);
    chk("reset_flush", 32'(bus0.flush), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_instr(8'h00, 8'h00, 8'h00, 0, 0);
    run_instr(8'hC4, 8'h00, 8'h10, 0, 0);
    run_instr(8'hC2, 8'hFF, 8'h40, 1, 0);
    run_instr(8'hC6, 8'h80, 8'h99, 0, 0);
    run_instr(8'hC6, 8'h7F, 8'h20, 0, 0);

    for (int op = 0; op < 8; op++)
      for (int k = 0; k < 5; k++)
        run_instr(8'hC0 | 8'(op), opnds[k], 8'($urandom), 0, 0);

    run_instr(8'hC4, 8'h00, 8'hFF, 0, 0);
    run_instr(8'h41, 8'h00, 8'h00, 0, 3);
    run_instr(8'hC4, 8'h00, 8'h33, 0, 0);
    run_instr(8'hC4, 8'h00, 8'h33, 0, 0);

    for (int i = 0; i < 40; i++)
      run_instr(8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 1)));

    // Reset while a taken jump sits in EVAL.
    @(negedge clk);
    chk("pre_rst_req", 32'(bus0.fetch_req), 32'd1);
    @(posedge clk); #1;
    bus0.instr_valid = 1'b1; bus0.instr = 8'hC4; bus0.target = 8'h55;
    @(posedge clk); #1;
    bus0.instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_eval_taken", 32'(bus0.branch_taken), 32'd0);
    chk("rst_eval_done", 32'(bus0.instr_done), 32'd0);
    chk("rst_eval_pc", 32'(bus0.pc), 32'h0);
    @(negedge clk);
    chk("rst_eval_count", 32'(bus0.taken_count), 32'h0);
    chk("rst_eval_req", 32'(bus0.fetch_req), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_pc = 8'h00; m_cnt = 0;
    run_instr(8'h00, 8'h00, 8'h00, 0, 0);
    run_instr(8'hC5, 8'h01, 8'h77, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Fetch/branch sequencer for the 8-bit CPU. Owns the program counter and issues instruction fetches.
- Steers conditional jumps (mode bits 11) by testing a signed register operand against zero, then loading the jump target or falling through.
- Sits between instruction memory and the register file. Provides the PC, the fetch strobe and branch status to the rest of the core.

Parameters:
ADDR_WIDTH, 8, width of PC, fetch address and jump target
RESET_PC, 0, PC value loaded on reset
COUNT_WIDTH, 16, width of saturating taken-branch counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous active-high reset
stall  in  1  freeze sequencer; state, PC and counter hold
instr_valid  in  1  instr/operand/target valid this cycle (fetch response)
instr  in  8  fetched instruction; [7:6] mode, [2:0] condition op
operand  in  8  signed register value under test
target  in  ADDR_WIDTH  jump destination
fetch_req  out  1  one-cycle fetch strobe
pc  out  ADDR_WIDTH  current PC / fetch address
instr_done  out  1  one-cycle pulse, instruction retired
branch_taken  out  1  one-cycle pulse, conditional jump taken
flush  out  1  one-cycle pulse in REDIRECT, discard in-flight data
taken_count  out  COUNT_WIDTH  saturating count of taken jumps

Behaviour:
- Reset (async, active-high):
  - state=FETCH, pc=RESET_PC, taken_count=0.
  - All pulse outputs 0 immediately on assertion.
  - Reset mid-operation discards any latched instruction.
- States: FETCH, WAIT, EVAL, REDIRECT. All transitions are on the rising clock edge and only when stall=0.
- FETCH: fetch_req=1 (combinational from state, gated by !stall); pc drives the address; next state WAIT.
- WAIT: instr_valid is sampled only here.
  - instr_valid=0: stay in WAIT.
  - instr_valid=1 and instr[7:6]==2'b11: latch instr[2:0], operand and target; go to EVAL.
  - instr_valid=1, any other mode: pc<=pc+1; instr_done=1 this cycle; go to FETCH.
- EVAL: evaluate the latched op against the latched operand (signed, two's complement):
  - 000 never; 001 ==0; 010 <0; 011 <=0
  - 100 always; 101 !=0; 110 >0; 111 >=0
  - Taken: pc<=target; branch_taken=1; instr_done=1; taken_count increments (saturates at all-ones, no wrap); go to REDIRECT.
  - Not taken: pc<=pc+1; instr_done=1; go to FETCH.
- REDIRECT: flush=1 for this single cycle; go to FETCH.
- PC arithmetic: pc+1 is modulo 2^ADDR_WIDTH, so all-ones wraps to 0. A jump target equal to the current pc is legal (tight loop).
- Stall:
  - Stall has priority over every transition. State, pc, latches and taken_count hold.
  - fetch_req, instr_done, branch_taken and flush are forced 0 while stall=1.
  - instr_valid during stall is ignored; memory must hold its response until stall drops.
- Pulse semantics: each pulse is high for exactly one unstalled cycle and is combinational from state and inputs. instr_done and branch_taken coincide on a taken jump.
- Latency:
  - Non-branch instruction: 2 cycles (FETCH+WAIT) with zero wait states.
  - Not-taken branch: 3 cycles.
  - Taken branch: 4 cycles.
- No operation leaves the FSM outside the four states; illegal encodings recover to FETCH.

Test Plan:
- Reset then release, instr_valid=1 every WAIT with instr=8'h00 -> fetch_req on alternate cycles, pc=0,1,2,3; instr_done pulse per instruction; taken_count=0.
- pc=8'h10, instr=8'hC2 (op 010), operand=8'hFF (-1), target=8'h40 -> EVAL takes jump; branch_taken=1, flush next cycle, next fetch at pc=8'h40, taken_count=1.
- instr=8'hC6 (op 110) with operand=8'h80 (-128) -> not taken, pc increments by 1, no flush; repeat with operand=8'h7F -> taken.
- All 8 ops × operands {8'h80, 8'hFF, 8'h00, 8'h01, 8'h7F} -> taken/not-taken matches the table (000 never, 100 always).
- pc=8'hFF with non-branch instruction -> pc wraps to 8'h00; assert stall for 3 cycles while in WAIT with instr_valid=1 -> pc/state frozen, no pulses, instruction accepted on the first unstalled cycle.
- Preload taken_count near saturation (COUNT_WIDTH=2 build, 4 taken jumps) -> counter stops at 3. Assert reset during EVAL -> pc=RESET_PC, state FETCH, no branch_taken pulse.
